// File: rtl/search_8_comparators.sv
// rtl/search_8_comparators.sv - 32-nucleotide key search over a 512-nucleotide word
// Eight nucleotide-aligned windows are compared per clock, and match is a sticky flop.
module search_8_comparators #(
  parameter int DATA_WIDTH = 1024,
  parameter int KEY_WIDTH  = 64,
  parameter int SYM_WIDTH  = 2,
  parameter int NUM_CMP    = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [KEY_WIDTH-1:0]  key,
  output logic                  match
);

  localparam int NUM_WIN  = (DATA_WIDTH - KEY_WIDTH) / SYM_WIDTH + 1;
  localparam int LAST_GRP = (NUM_WIN - 1) / NUM_CMP;
  localparam int STRIDE   = NUM_CMP * SYM_WIDTH;
  localparam int SEG_W    = KEY_WIDTH + (NUM_CMP - 1) * SYM_WIDTH;
  localparam int EXT_W    = LAST_GRP * STRIDE + SEG_W;
  localparam int PAD_W    = EXT_W - DATA_WIDTH;
  localparam int GW       = $clog2(LAST_GRP + 1);
  localparam int IW       = $clog2(EXT_W);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    FOUND  = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                state;
  logic [GW-1:0]         grp;
  logic [DATA_WIDTH-1:0] data_q;
  logic [KEY_WIDTH-1:0]  key_q;

  logic [EXT_W-1:0]      data_ext;
  logic [IW-1:0]         base;
  logic [SEG_W-1:0]      seg;
  logic [NUM_CMP-1:0]    eq;
  logic [NUM_CMP-1:0]    valid;
  logic                  hit;

  // The zero padding lets the final group use the same slice width.
  // Its padded windows are masked off by valid.
  assign data_ext = {data_q, {PAD_W{1'b0}}};
  assign base     = IW'(EXT_W - 1) - IW'(grp) * IW'(STRIDE);
  assign seg      = data_ext[base -: SEG_W];

  always_comb begin
    eq    = '0;
    valid = '0;
    for (int j = 0; j < NUM_CMP; j++) begin
      eq[j]    = (seg[SEG_W-1-SYM_WIDTH*j -: KEY_WIDTH] == key_q);
      valid[j] = ((int'(grp) * NUM_CMP + j) < NUM_WIN);
    end
  end

  assign hit = |(eq & valid);

  always_ff @(posedge clock) begin
    if (!reset) begin
      data_q <= data;
      key_q  <= key;
      grp    <= '0;
      state  <= SEARCH;
      match  <= 1'b0;
    end else begin
      case (state)
        SEARCH: begin
          if (hit) begin
            match <= 1'b1;
            state <= FOUND;
          end else if (grp == GW'(LAST_GRP)) begin
            state <= DONE;
          end else begin
            grp <= grp + 1'b1;
          end
        end
        FOUND:   match <= 1'b1;
        DONE:    match <= 1'b0;
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_search_8_comparators.sv
// tb/tb_search_8_comparators.sv - directed self-checking bench for search_8_comparators
module tb_search_8_comparators;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [1023:0] data  = '0;
  logic [63:0]   key   = '0;
  logic          match;

  int errors = 0;
  int checks = 0;

  logic [1023:0] d;
  logic [63:0]   k;

  search_8_comparators dut (
    .clock(clock),
    .reset(reset),
    .data (data),
    .key  (key),
    .match(match)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [1023:0] dv, input logic [63:0] kv);
    data  = dv;
    key   = kv;
    reset = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [1023:0] rand_data();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    // Test 1: key in window 0, hit on first edge, sticky for 1000 clocks
    d = rand_data();
    k = 64'h4EBA3320973BA2B8;
    d[1023 -: 64] = k;
    do_reset(d, k);
    check("t1_reset_match", {1'b0, match}, 2'd0);
    check("t1_reset_state", 2'(dut.state), 2'd0);
    step();
    check("t1_edge1", {1'b0, match}, 2'd1);
    for (int i = 0; i < 1000; i++) begin
      step();
      if (i % 250 == 0) check("t1_sticky", {1'b0, match}, 2'd1);
    end
    check("t1_sticky_end", {1'b0, match}, 2'd1);
    check("t1_state_found", 2'(dut.state), 2'd1);

    // Test 2: key only in window 480, the last valid window
    d = rand_data();
    k = d[63:0];
    do_reset(d, k);
    check("t2_reset_clears", {1'b0, match}, 2'd0);
    for (int i = 1; i <= 60; i++) begin
      step();
      check("t2_pre", {1'b0, match}, 2'd0);
    end
    step();
    check("t2_edge61", {1'b0, match}, 2'd1);
    for (int i = 0; i < 5; i++) step();
    check("t2_hold", {1'b0, match}, 2'd1);

    // Test 3: key at window 9 (group 1, comparator 1); inputs change after release
    d = rand_data();
    k = d[1005 -: 64];
    do_reset(d, k);
    data = '0;
    key  = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    check("t3_edge1", {1'b0, match}, 2'd0);
    step();
    check("t3_edge2", {1'b0, match}, 2'd1);

    // Test 4: absent key, all-zero data; DONE after 61 clocks
    do_reset('0, 64'h0000_0000_0000_0003);
    for (int i = 1; i <= 60; i++) step();
    check("t4_state_edge60", 2'(dut.state), 2'd0);
    step();
    check("t4_state_edge61", 2'(dut.state), 2'd2);
    for (int i = 62; i <= 200; i++) begin
      step();
      if (i % 50 == 0) check("t4_nomatch", {1'b0, match}, 2'd0);
    end
    check("t4_nomatch_end", {1'b0, match}, 2'd0);

    // Test 5: key only at an odd bit offset
    d = rand_data();
    k = d[1022 -: 64];
    do_reset(d, k);
    for (int i = 1; i <= 70; i++) begin
      step();
      if (i % 10 == 0) check("t5_odd", {1'b0, match}, 2'd0);
    end
    check("t5_done", 2'(dut.state), 2'd2);

    // Test 6: key at window 300; reset at edge 20 with zeroed data
    d = rand_data();
    k = d[423 -: 64];
    k[0] = 1'b1;
    d[423 -: 64] = k;
    do_reset(d, k);
    for (int i = 1; i <= 19; i++) begin
      step();
      check("t6_pre", {1'b0, match}, 2'd0);
    end
    do_reset('0, k);
    check("t6_mid_reset", {1'b0, match}, 2'd0);
    for (int i = 1; i <= 70; i++) begin
      step();
      if (i % 10 == 0) check("t6_zero_data", {1'b0, match}, 2'd0);
    end
    do_reset(d, k);
    for (int i = 1; i <= 37; i++) step();
    check("t6_edge37", {1'b0, match}, 2'd0);
    step();
    check("t6_edge38", {1'b0, match}, 2'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
